// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding the architectural HI/LO pair.
// mult/multu/div/divu run for MULT_CYCLES/DIV_CYCLES cycles with Busy high,
// then commit to HI/LO; mthi/mtlo write in a single cycle with no Busy.
// Optional feature macro: MD_MADD_EN enables madd/maddu (MDOp 110/111),
// which accumulate A*B into HI:LO. Without it those codes are no-ops.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_op;
`ifdef MD_MADD_EN
    logic [63:0]      r_acc;
`endif

    logic        w_is_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;
    logic        w_commit;

    // Pending result derived from the operands latched at Start.
    // Division works on magnitudes so that 0x80000000 / -1 needs no special
    // case: the magnitude quotient 0x80000000 re-signs to itself.
    always_comb begin
        w_is_signed = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD);
        w_a_ext     = w_is_signed ? {{32{r_a[31]}}, r_a} : {32'h0000_0000, r_a};
        w_b_ext     = w_is_signed ? {{32{r_b[31]}}, r_b} : {32'h0000_0000, r_b};
        w_prod      = w_a_ext * w_b_ext;

        w_a_neg = w_is_signed & r_a[31];
        w_b_neg = w_is_signed & r_b[31];
        w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
        w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
        w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
        w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
        w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

        w_result = w_prod;
        w_commit = 1'b1;
        case (r_op)
            OP_DIV, OP_DIVU: begin
                w_result = {w_rem, w_quot};
                w_commit = (r_b != 32'd0);
            end
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
                w_result = r_acc + w_prod;
                w_commit = 1'b1;
            end
`endif
            default: begin
                w_result = w_prod;
                w_commit = 1'b1;
            end
        endcase
    end

    // Control FSM: accepts Start in IDLE, counts down in RUN, commits at cnt=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'h0000_0000;
            r_lo    <= 32'h0000_0000;
            r_a     <= 32'h0000_0000;
            r_b     <= 32'h0000_0000;
            r_op    <= 3'b000;
`ifdef MD_MADD_EN
            r_acc   <= 64'h0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            OP_MULT, OP_MULTU: begin
                                r_a     <= A;
                                r_b     <= B;
                                r_op    <= MDOp;
                                r_cnt   <= MULT_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a     <= A;
                                r_b     <= B;
                                r_op    <= MDOp;
                                r_cnt   <= DIV_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
`ifdef MD_MADD_EN
                            OP_MADD, OP_MADDU: begin
                                r_a     <= A;
                                r_b     <= B;
                                r_op    <= MDOp;
                                r_acc   <= {r_hi, r_lo};
                                r_cnt   <= MULT_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
`else
                            OP_MADD, OP_MADDU: begin
                                r_state <= S_IDLE;
                            end
`endif
                            default: r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        if (w_commit) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the stimulus process predicts HI/LO and the
// Busy duration of each op with 64-bit integer arithmetic and queues it; a
// monitor process pops and compares when the DUT completes the operation.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    bit          pend   = 1'b0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: predicted HI/LO and busy length for one op.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          g;
        g = 0;
        while (Busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("wait_not_busy", 32'(Busy), 32'd0);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        e.busy = 0;
        case (op)
            3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; e.busy = 5; end
            3'd1: begin p = 64'(ua * ub); {m_hi, m_lo} = p; e.busy = 5; end
            3'd2: begin
                e.busy = 10;
                if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            3'd3: begin
                e.busy = 10;
                if (b != 32'd0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MD_MADD_EN
            3'd6: begin p = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = p; e.busy = 5; end
            3'd7: begin p = {m_hi, m_lo} + 64'(ua * ub); {m_hi, m_lo} = p; e.busy = 5; end
`endif
            default: e.busy = 0;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        sbq.push_back(e);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Monitor: one sample per cycle, #1 after the rising edge.
    initial begin : monitor
        int   bc;
        exp_t e;
        bc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en || reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (Busy) begin
                        bc++;
                        if (bc > 50) begin
                            check("busy_timeout", 32'(bc), 32'd10);
                            pend = 1'b0;
                        end
                    end else begin
                        e = sbq.pop_front();
                        check("busy_len", 32'(bc), 32'(e.busy));
                        check("hi", HI, e.hi);
                        check("lo", LO, e.lo);
                        pend = 1'b0;
                    end
                end
                if (Start) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_start", 32'd1, 32'd0);
                    end else if (Busy) begin
                        pend = 1'b1;
                        bc   = 1;
                    end else begin
                        e = sbq.pop_front();
                        check("busy_len", 32'd0, 32'(e.busy));
                        check("hi", HI, e.hi);
                        check("lo", LO, e.lo);
                    end
                end
            end
        end
    end

    initial begin : stim
        int  g;
        bit  seen_busy;
        logic [2:0]  op;
        logic [31:0] a, b;
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'b000;
        A     = 32'h0;
        B     = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        reset = 1'b0;

        // Reset during a divide: preload HI/LO so the clear is visible.
        @(negedge clk);
        Start = 1'b1; MDOp = 3'b100; A = 32'hDEAD_BEEF;
        @(negedge clk);
        MDOp = 3'b101; A = 32'hCAFE_F00D;
        @(negedge clk);
        MDOp = 3'b011; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        check("rst_mid_busy_c1", 32'(Busy), 32'd1);
        check("rst_mid_hi_pre", HI, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_hi", HI, 32'h0);
        check("rst_mid_lo", LO, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen_busy = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (Busy) seen_busy = 1'b1;
        end
        check("rst_no_busy_after", 32'(seen_busy), 32'd0);
        check("rst_no_commit_hi", HI, 32'h0);
        check("rst_no_commit_lo", LO, 32'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;

        // Directed scoreboard sequence.
        mon_en = 1'b1;
        issue(3'd4, 32'h1234_5678, 32'h0);
        issue(3'd5, 32'h9ABC_DEF0, 32'h0);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        issue(3'd3, 32'd7, 32'd0);
        issue(3'd2, 32'd5, 32'd0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        issue(3'd4, 32'h0000_0000, 32'h0);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0);
        issue(3'd7, 32'd1, 32'd1);
        issue(3'd6, 32'hFFFF_FFFF, 32'd5);

        // Randomized ops with a bias towards zero divisors and edge operands.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(op, a, b);
        end

        g = 0;
        while ((sbq.size() != 0 || pend) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        check("final_hi", HI, m_hi);
        check("final_lo", LO, m_lo);
        check("final_busy", 32'(Busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
